// File: rtl/escritura_rtc_if.sv
// Signal bundle between the general control FSM, the write engine and the RTC AD bus.
// The slave side is the write engine; the master side is whoever requests writes and watches the bus.
interface escritura_rtc_if;
  logic       Inicio_W;
  logic [7:0] dir;
  logic [7:0] dato;
  logic       cs_n;
  logic       wr_n;
  logic       ad_n;
  logic       ad_oe;
  logic [7:0] ad_out;
  logic       busy;
  logic       Fin_W;

  modport master (
    output Inicio_W, dir, dato,
    input  cs_n, wr_n, ad_n, ad_oe, ad_out, busy, Fin_W
  );

  modport slave (
    input  Inicio_W, dir, dato,
    output cs_n, wr_n, ad_n, ad_oe, ad_out, busy, Fin_W
  );
endinterface

// File: rtl/escritura_rtc.sv
// RTC write-cycle engine: address phase, recovery gap, data phase on a multiplexed AD bus.
// Every bus strobe is a flip-flop output decoded from the next state.
module escritura_rtc #(
  parameter int T_SU  = 2,
  parameter int T_PW  = 4,
  parameter int T_HD  = 2,
  parameter int T_REC = 3
) (
  input  logic           clk,
  input  logic           reset,
  escritura_rtc_if.slave rtc
);

  typedef enum logic [3:0] {
    IDLE,
    A_SU,
    A_PW,
    A_HD,
    REC,
    D_SU,
    D_PW,
    D_HD,
    DONE
  } state_t;

  localparam logic [3:0] SU_LOAD  = 4'(T_SU - 1);
  localparam logic [3:0] PW_LOAD  = 4'(T_PW - 1);
  localparam logic [3:0] HD_LOAD  = 4'(T_HD - 1);
  localparam logic [3:0] REC_LOAD = 4'(T_REC - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       inicio_reg;
  logic       armed_reg, armed_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;
  logic       start;

  logic       cs_n_reg, cs_n_next;
  logic       wr_n_reg, wr_n_next;
  logic       ad_n_reg, ad_n_next;
  logic       ad_oe_reg, ad_oe_next;
  logic [7:0] ad_out_reg, ad_out_next;
  logic       busy_reg, busy_next;
  logic       fin_reg, fin_next;

  // Counter value loaded on entry so that each state lasts exactly its parameter count.
  function automatic logic [3:0] reload(input state_t s);
    case (s)
      A_SU, D_SU: reload = SU_LOAD;
      A_PW, D_PW: reload = PW_LOAD;
      A_HD, D_HD: reload = HD_LOAD;
      REC:        reload = REC_LOAD;
      default:    reload = 4'd0;
    endcase
  endfunction

  function automatic state_t successor(input state_t s);
    case (s)
      A_SU:    successor = A_PW;
      A_PW:    successor = A_HD;
      A_HD:    successor = REC;
      REC:     successor = D_SU;
      D_SU:    successor = D_PW;
      D_PW:    successor = D_HD;
      D_HD:    successor = DONE;
      default: successor = IDLE;
    endcase
  endfunction

  // armed only becomes set after Inicio_W has been seen low since reset, so a level
  // already high when reset is released never looks like a fresh request.
  always_comb begin
    start      = rtc.Inicio_W && !inicio_reg && armed_reg &&
                 (state_reg == IDLE || state_reg == DONE);
    armed_next = armed_reg || !rtc.Inicio_W;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;

    if (start) begin
      state_next = A_SU;
      addr_next  = rtc.dir;
      data_next  = rtc.dato;
    end else if (state_reg == DONE) begin
      state_next = IDLE;
    end else if (state_reg != IDLE) begin
      if (cnt_reg == 4'd0) begin
        state_next = successor(state_reg);
      end else begin
        cnt_next = cnt_reg - 4'd1;
      end
    end

    if (state_next != state_reg) begin
      cnt_next = reload(state_next);
    end
  end

  // Bus outputs are decoded from the state being entered so they register with it.
  always_comb begin
    cs_n_next   = 1'b1;
    wr_n_next   = 1'b1;
    ad_n_next   = 1'b1;
    ad_oe_next  = 1'b0;
    ad_out_next = ad_out_reg;
    busy_next   = (state_next != IDLE);
    fin_next    = (state_next == DONE);

    case (state_next)
      A_SU, A_PW, A_HD: begin
        cs_n_next   = 1'b0;
        wr_n_next   = (state_next != A_PW);
        ad_n_next   = 1'b0;
        ad_oe_next  = 1'b1;
        ad_out_next = addr_next;
      end
      REC: begin
        ad_n_next   = 1'b0;
        ad_out_next = addr_next;
      end
      D_SU, D_PW, D_HD: begin
        cs_n_next   = 1'b0;
        wr_n_next   = (state_next != D_PW);
        ad_oe_next  = 1'b1;
        ad_out_next = data_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      inicio_reg <= 1'b0;
      armed_reg  <= 1'b0;
      addr_reg   <= 8'h00;
      data_reg   <= 8'h00;
      cs_n_reg   <= 1'b1;
      wr_n_reg   <= 1'b1;
      ad_n_reg   <= 1'b1;
      ad_oe_reg  <= 1'b0;
      ad_out_reg <= 8'h00;
      busy_reg   <= 1'b0;
      fin_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      inicio_reg <= rtc.Inicio_W;
      armed_reg  <= armed_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      cs_n_reg   <= cs_n_next;
      wr_n_reg   <= wr_n_next;
      ad_n_reg   <= ad_n_next;
      ad_oe_reg  <= ad_oe_next;
      ad_out_reg <= ad_out_next;
      busy_reg   <= busy_next;
      fin_reg    <= fin_next;
    end
  end

  assign rtc.cs_n   = cs_n_reg;
  assign rtc.wr_n   = wr_n_reg;
  assign rtc.ad_n   = ad_n_reg;
  assign rtc.ad_oe  = ad_oe_reg;
  assign rtc.ad_out = ad_out_reg;
  assign rtc.busy   = busy_reg;
  assign rtc.Fin_W  = fin_reg;

endmodule

// File: tb/tb_escritura_rtc.sv
// Directed bench for escritura_rtc: default-timing instance plus an all-ones timing instance.
module tb_escritura_rtc;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  escritura_rtc_if bus ();
  escritura_rtc_if bus_min ();

  escritura_rtc dut (
    .clk   (clk),
    .reset (reset),
    .rtc   (bus.slave)
  );

  escritura_rtc #(.T_SU(1), .T_PW(1), .T_HD(1), .T_REC(1)) dut_min (
    .clk   (clk),
    .reset (reset),
    .rtc   (bus_min.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic test_reset;
    logic [13:0] obs;
    reset = 1'b0;
    bus.Inicio_W = 1'b0; bus.dir = 8'h00; bus.dato = 8'h00;
    bus_min.Inicio_W = 1'b0; bus_min.dir = 8'h00; bus_min.dato = 8'h00;
    repeat (3) @(negedge clk);
    obs = {bus.cs_n, bus.wr_n, bus.ad_n, bus.ad_oe, bus.busy, bus.Fin_W, bus.ad_out};
    vectors++;
    if (obs !== {6'b111000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_default got=%h want=%h", obs, {6'b111000, 8'h00});
    end
    obs = {bus_min.cs_n, bus_min.wr_n, bus_min.ad_n, bus_min.ad_oe, bus_min.busy, bus_min.Fin_W, bus_min.ad_out};
    vectors++;
    if (obs !== {6'b111000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_min got=%h want=%h", obs, {6'b111000, 8'h00});
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus.cs_n, bus.wr_n, bus.ad_n, bus.ad_oe, bus.busy, bus.Fin_W, bus.ad_out};
    vectors++;
    if (obs !== {6'b111000, 8'h00}) begin
      miscompares++;
      $display("FAIL idle_after_reset got=%h want=%h", obs, {6'b111000, 8'h00});
    end
    $display("reset: outputs checked in and after reset");
  endtask

  // Also covers input change mid-transaction: dir/dato go to 0xFF during A_PW.
  task automatic test_default_write;
    logic e_cs, e_wr, e_oe, e_adn, e_busy, e_fin, chk_adn;
    logic [7:0] e_ad;
    logic [13:0] obs, exp_v;
    bus.dir = 8'h21; bus.dato = 8'h45; bus.Inicio_W = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i == 1) bus.Inicio_W = 1'b0;
      e_cs = 1'b1; e_wr = 1'b1; e_oe = 1'b0; e_adn = 1'b1; e_busy = 1'b1; e_fin = 1'b0;
      e_ad = 8'h21; chk_adn = 1'b1;
      if (i <= 8) begin
        e_cs = 1'b0; e_oe = 1'b1; e_adn = 1'b0; e_wr = !(i >= 3 && i <= 6);
      end else if (i <= 11) begin
        chk_adn = 1'b0;
      end else if (i <= 19) begin
        e_cs = 1'b0; e_oe = 1'b1; e_ad = 8'h45; e_wr = !(i >= 14 && i <= 17);
      end else if (i == 20) begin
        e_fin = 1'b1; e_ad = 8'h45;
      end else begin
        e_busy = 1'b0; e_ad = 8'h45;
      end
      obs   = {bus.cs_n, bus.wr_n, bus.ad_oe, bus.busy, bus.Fin_W, bus.ad_out, 1'b0};
      exp_v = {e_cs, e_wr, e_oe, e_busy, e_fin, e_ad, 1'b0};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL default_write cycle=%0d got=%h want=%h", i, obs, exp_v);
      end
      if (chk_adn) begin
        vectors++;
        if (bus.ad_n !== e_adn) begin
          miscompares++;
          $display("FAIL default_ad_n cycle=%0d got=%b want=%b", i, bus.ad_n, e_adn);
        end
      end
      if (i == 4) begin bus.dir = 8'hFF; bus.dato = 8'hFF; end
    end
    $display("default write: dir=21 dato=45, dir/dato changed to FF in A_PW");
  endtask

  task automatic test_held_request;
    int fins = 0;
    int busy_seen = 0;
    bus.dir = 8'h10; bus.dato = 8'h20; bus.Inicio_W = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.Fin_W === 1'b1) fins++;
    end
    vectors++;
    if (fins != 1) begin
      miscompares++;
      $display("FAIL held_fin_count got=%0d want=1", fins);
    end
    bus.Inicio_W = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen++;
    end
    vectors++;
    if (busy_seen != 0) begin
      miscompares++;
      $display("FAIL held_busy_after got=%0d busy cycles want=0", busy_seen);
    end
    $display("held request: 50 cycles high, Fin_W count=%0d", fins);
  endtask

  task automatic test_busy_request;
    int fins = 0;
    bus.dir = 8'h33; bus.dato = 8'h44; bus.Inicio_W = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus.Inicio_W = 1'b0;
      if (i == 15) begin
        vectors++;
        if (bus.wr_n !== 1'b0 || bus.ad_out !== 8'h44) begin
          miscompares++;
          $display("FAIL busy_in_d_pw got wr_n=%b ad=%h want wr_n=0 ad=44", bus.wr_n, bus.ad_out);
        end
        bus.Inicio_W = 1'b1;
      end
      if (i == 16) bus.Inicio_W = 1'b0;
      if (i == 20) begin
        vectors++;
        if (bus.Fin_W !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_fin_time got=%b want=1", bus.Fin_W);
        end
      end
      if (bus.Fin_W === 1'b1) fins++;
    end
    vectors++;
    if (fins != 1) begin
      miscompares++;
      $display("FAIL busy_fin_count got=%0d want=1", fins);
    end
    $display("request while busy: Fin_W count=%0d", fins);
  endtask

  task automatic test_reset_mid;
    int busy_seen = 0;
    int fins = 0;
    logic [4:0] obs;
    bus.dir = 8'h55; bus.dato = 8'h66; bus.Inicio_W = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) bus.Inicio_W = 1'b0;
    end
    #2 reset = 1'b0;
    bus.Inicio_W = 1'b1;
    #1;
    obs = {bus.cs_n, bus.wr_n, bus.ad_oe, bus.busy, bus.Fin_W};
    vectors++;
    if (obs !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_mid_async got=%b want=11000", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen++;
      if (bus.Fin_W !== 1'b0) fins++;
    end
    vectors++;
    if (busy_seen != 0 || fins != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_restart got busy=%0d fin=%0d want 0/0", busy_seen, fins);
    end
    bus.Inicio_W = 1'b0;
    @(negedge clk);
    bus.Inicio_W = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 1) bus.Inicio_W = 1'b0;
      if (bus.Fin_W === 1'b1) fins++;
    end
    vectors++;
    if (fins != 1) begin
      miscompares++;
      $display("FAIL reset_mid_fresh_start got=%0d Fin_W want=1", fins);
    end
    $display("reset during D_PW: aborted, fresh edge afterwards completed");
  endtask

  // All-ones timing: two transactions, the second sampled on the edge that ends DONE.
  task automatic test_back_to_back;
    logic [9:0] obs, exp_v;
    logic [7:0] e_addr, e_data;
    int j;
    bus_min.dir = 8'h3C; bus_min.dato = 8'hC3; bus_min.Inicio_W = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      j = (i > 8) ? i - 8 : i;
      e_addr = (i <= 8) ? 8'h3C : 8'h5A;
      e_data = (i <= 8) ? 8'hC3 : 8'hA5;
      obs   = {bus_min.cs_n, bus_min.wr_n, bus_min.ad_out};
      exp_v = {!(j == 1 || j == 2 || j == 3 || j == 5 || j == 6 || j == 7),
               !(j == 2 || j == 6), (j <= 4) ? e_addr : e_data};
      vectors++;
      if (obs !== exp_v || bus_min.Fin_W !== (j == 8)) begin
        miscompares++;
        $display("FAIL min_params cycle=%0d got=%h fin=%b want=%h fin=%b",
                 i, obs, bus_min.Fin_W, exp_v, (j == 8));
      end
      if (i == 1 || i == 9) bus_min.Inicio_W = 1'b0;
      if (i == 8) begin
        bus_min.dir = 8'h5A; bus_min.dato = 8'hA5; bus_min.Inicio_W = 1'b1;
      end
    end
    $display("min params: 3C/C3 then back-to-back 5A/A5");
  endtask

  initial begin
    test_reset();
    test_default_write();
    repeat (3) @(negedge clk);
    test_held_request();
    test_busy_request();
    test_reset_mid();
    repeat (3) @(negedge clk);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
